// File: rtl/win_buzzer_pkg.sv
// Shared types and 50 MHz timing defaults for the win buzzer driver.
// The ack-abort feature is enabled by defining WIN_BUZZER_ACK_EN.
package win_buzzer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BEEP    = 3'd1,
    ST_GAP     = 3'd2,
    ST_DONE    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  localparam int unsigned DEF_TONE_HALF_PERIOD = 32'd25000;
  localparam int unsigned DEF_BEEP_CYCLES      = 32'd10000000;
  localparam int unsigned DEF_GAP_CYCLES       = 32'd5000000;
  localparam int unsigned DEF_NUM_BEEPS        = 32'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/win_buzzer_driver_tone_gen.sv
// Square-wave tone generator: starts high on the first enabled cycle and
// toggles every HALF_PERIOD cycles; clr returns it to silence.
module tone_gen
  import win_buzzer_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = DEF_TONE_HALF_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tone
);

  localparam int unsigned   CW   = cnt_width(HALF_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 32'd1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tone_q, tone_d;
  logic          run_q, run_d;

  // Next-state for the half-period divider and toggle flop.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    run_d  = run_q;
    if (clr) begin
      cnt_d  = '0;
      tone_d = 1'b0;
      run_d  = 1'b0;
    end else if (en) begin
      if (!run_q) begin
        cnt_d  = '0;
        tone_d = 1'b1;
        run_d  = 1'b1;
      end else if (cnt_q == LAST) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Divider and tone registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
      run_q  <= run_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/win_buzzer_driver.sv
// Win buzzer driver: plays NUM_BEEPS tone bursts on a rising edge of buzz_in,
// then pulses stop. Define WIN_BUZZER_ACK_EN to let ack abort the sequence.
module win_buzzer_driver
  import win_buzzer_pkg::*;
#(
  parameter int unsigned TONE_HALF_PERIOD = DEF_TONE_HALF_PERIOD,
  parameter int unsigned BEEP_CYCLES      = DEF_BEEP_CYCLES,
  parameter int unsigned GAP_CYCLES       = DEF_GAP_CYCLES,
  parameter int unsigned NUM_BEEPS        = DEF_NUM_BEEPS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic buzz_in,
  input  logic ack,
  output logic speaker,
  output logic stop,
  output logic busy
);

  localparam int unsigned      DUR_W      = cnt_width(max_u(BEEP_CYCLES, GAP_CYCLES));
  localparam int unsigned      BC_W       = cnt_width(NUM_BEEPS + 32'd1);
  localparam logic [DUR_W-1:0] BEEP_LAST  = DUR_W'(BEEP_CYCLES - 32'd1);
  localparam logic [DUR_W-1:0] GAP_LAST   = DUR_W'(GAP_CYCLES - 32'd1);
  localparam logic [BC_W-1:0]  BEEP_FINAL = BC_W'(NUM_BEEPS - 32'd1);

  state_e           state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [BC_W-1:0]  beeps_q, beeps_d;
  logic             buzz_q;
  logic             armed_q;
  logic             busy_q, busy_d;
  logic             stop_q, stop_d;
  logic             trigger_s;
  logic             ack_s;
  logic             tone_en_s;
  logic             tone_clr_s;

`ifdef WIN_BUZZER_ACK_EN
  assign ack_s = ack;
`else
  logic unused_ack_s;
  assign unused_ack_s = ack;
  assign ack_s        = 1'b0;
`endif

  // armed_q blocks the first cycle after reset, so a level already high at
  // release is not mistaken for a fresh rising edge.
  assign trigger_s = armed_q & buzz_in & ~buzz_q;

  // Sequencer next-state, counters and registered-output targets.
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    beeps_d = beeps_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_s) begin
          state_d = ST_BEEP;
          beeps_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BEEP: begin
        if (ack_s) begin
          state_d = ST_DONE;
          beeps_d = beeps_q + 1'b1;
        end else if (dur_q == BEEP_LAST) begin
          state_d = (beeps_q == BEEP_FINAL) ? ST_DONE : ST_GAP;
          beeps_d = beeps_q + 1'b1;
        end else begin
          dur_d = dur_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (ack_s) begin
          state_d = ST_DONE;
        end else if (dur_q == GAP_LAST) begin
          state_d = ST_BEEP;
        end else begin
          dur_d = dur_q + 1'b1;
        end
      end
      ST_DONE:    state_d = ST_HOLDOFF;
      ST_HOLDOFF: begin
        if (!buzz_in) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLDOFF;
        end
      end
      default:    state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      dur_d = '0;
    end else begin
      dur_d = dur_d;
    end

    busy_d     = (state_d == ST_BEEP) || (state_d == ST_GAP);
    stop_d     = (state_d == ST_DONE);
    tone_en_s  = (state_d == ST_BEEP);
    tone_clr_s = (state_q == ST_BEEP) && (state_d != ST_BEEP);
  end

  // All sequencer state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dur_q   <= '0;
      beeps_q <= '0;
      buzz_q  <= 1'b0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      beeps_q <= beeps_d;
      buzz_q  <= buzz_in;
      armed_q <= 1'b1;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
    end
  end

  tone_gen #(
    .HALF_PERIOD(TONE_HALF_PERIOD)
  ) u_tone_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (tone_en_s),
    .clr    (tone_clr_s),
    .tone   (speaker)
  );

  assign stop = stop_q;
  assign busy = busy_q;

endmodule
